// File: rtl/mul_div_pkg.sv
// Shared types for mul_div_unit: operation encoding, FSM states and the
// iteration-counter width helper.
package mul_div_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULU = 2'b01,
    OP_DIV  = 2'b10,
    OP_DIVU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  // Bits needed to count WIDTH iterations down from WIDTH-1 to 0.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mul_div_sign_fix.sv
// Two's-complement conditional negation: gives operand magnitudes and
// applies result sign correction.
module mul_div_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (-val_i) : val_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiplier/divider, one step per RUN cycle.
// Define MUL_DIV_UNIT_DIV_EN to build divide support; otherwise op=1x is illegal.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz,
  output state_e           dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, mcand_q, acc_hi_q, acc_lo_q, hi_q, lo_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_lo_q, dbz_flag_q, busy_q, done_q, dbz_q;

  logic             is_signed, is_div;
  logic [WIDTH-1:0] mag_a, mag_b, fix_hi, fix_lo, step_hi_d, step_lo_d;
  logic [WIDTH:0]   mul_sum_d;

  assign is_signed = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);

  mul_div_sign_fix #(.W(WIDTH)) u_mag_a (
    .val_i(a_q), .neg_i(is_signed & a_q[WIDTH-1]), .val_o(mag_a));
  mul_div_sign_fix #(.W(WIDTH)) u_mag_b (
    .val_i(b_q), .neg_i(is_signed & b_q[WIDTH-1]), .val_o(mag_b));
  mul_div_sign_fix #(.W(2*WIDTH)) u_prod_fix (
    .val_i({acc_hi_q, acc_lo_q}), .neg_i(neg_lo_q), .val_o({fix_hi, fix_lo}));

  // Shift-add: multiplier sits in acc_lo and drains out the bottom.
  assign mul_sum_d = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);

`ifdef MUL_DIV_UNIT_DIV_EN
  logic             neg_hi_q;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [WIDTH:0]   div_shift_d, div_diff_d;

  mul_div_sign_fix #(.W(WIDTH)) u_quo_fix (
    .val_i(acc_lo_q), .neg_i(neg_lo_q), .val_o(quo_fix));
  mul_div_sign_fix #(.W(WIDTH)) u_rem_fix (
    .val_i(acc_hi_q), .neg_i(neg_hi_q), .val_o(rem_fix));

  // Restoring division: bit WIDTH of the difference is the borrow.
  assign div_shift_d = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff_d  = div_shift_d - {1'b0, mcand_q};

  always_comb begin
    step_hi_d = mul_sum_d[WIDTH:1];
    step_lo_d = {mul_sum_d[0], acc_lo_q[WIDTH-1:1]};
    if (is_div) begin
      step_hi_d = div_diff_d[WIDTH] ? div_shift_d[WIDTH-1:0] : div_diff_d[WIDTH-1:0];
      step_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff_d[WIDTH]};
    end
  end
`else
  assign step_hi_d = mul_sum_d[WIDTH:1];
  assign step_lo_d = {mul_sum_d[0], acc_lo_q[WIDTH-1:1]};
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      op_q       <= OP_MUL;
      a_q        <= '0;
      b_q        <= '0;
      mcand_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      cnt_q      <= '0;
      neg_lo_q   <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
      neg_hi_q   <= 1'b0;
`endif
      dbz_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q       <= op_e'(op);
            a_q        <= a;
            b_q        <= b;
            dbz_flag_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= INIT;
          end
        end
        INIT: begin
          neg_lo_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          cnt_q    <= CW'(WIDTH - 1);
          if (is_div) begin
`ifdef MUL_DIV_UNIT_DIV_EN
            neg_hi_q <= is_signed & a_q[WIDTH-1];
            if (b_q == '0) begin
              acc_hi_q   <= a_q;
              acc_lo_q   <= '1;
              dbz_flag_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              acc_hi_q <= '0;
              acc_lo_q <= mag_a;
              mcand_q  <= mag_b;
              state_q  <= RUN;
            end
`else
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            state_q  <= DONE;
`endif
          end else begin
            acc_hi_q <= '0;
            acc_lo_q <= mag_b;
            mcand_q  <= mag_a;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_hi_q <= step_hi_d;
          acc_lo_q <= step_lo_d;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: begin
`ifdef MUL_DIV_UNIT_DIV_EN
          acc_hi_q <= is_div ? rem_fix : fix_hi;
          acc_lo_q <= is_div ? quo_fix : fix_lo;
`else
          acc_hi_q <= fix_hi;
          acc_lo_q <= fix_lo;
`endif
          state_q  <= DONE;
        end
        DONE: begin
          hi_q    <= acc_hi_q;
          lo_q    <= acc_lo_q;
          dbz_q   <= dbz_flag_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbz       = dbz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32; divide vectors are built
// when MUL_DIV_UNIT_DIV_EN is defined, illegal-op vectors otherwise.
module tb_mul_div_unit;
  import mul_div_pkg::*;

  localparam int W = 32;

  // Handshake: start is sampled only in IDLE; done is a one-cycle pulse
  // with hi/lo/dbz valid and held until the next accepted start.
  logic         clk, clr, start, busy, done, dbz;
  logic [1:0]   op;
  logic [W-1:0] a, b, hi, lo;
  state_e       dbg_state;

  logic [2*W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbz(dbz),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input string tag, input logic [1:0] op_v,
                        input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input logic exp_dbz, input int exp_lat, input bit poke);
    int  n;
    bit  got_done;
    logic [2*W-1:0] exp_v;
    exp_q.push_back({exp_hi, exp_lo});
    @(negedge clk);
    start = 1'b1; op = op_v; a = a_v; b = b_v;
    @(posedge clk); #1;
    start = 1'b0;
    // Later operand changes must not leak into the result.
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    n = 0;
    got_done = 1'b0;
    while (!got_done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check({tag, ".busy"}, busy, 1'b1);
      if (done) got_done = 1'b1;
      if (poke) begin
        start = (n == 5);
        if (n == 5) begin op = 2'b00; a = 32'h7; b = 32'h9; end
      end
    end
    start = 1'b0;
    check({tag, ".done"}, got_done, 1'b1);
    check({tag, ".lat"}, n, exp_lat);
    exp_v = exp_q.pop_front();
    check({tag, ".res"}, {hi, lo}, exp_v);
    check({tag, ".dbz"}, dbz, exp_dbz);
    check({tag, ".busy_end"}, busy, 1'b0);
    @(posedge clk); #1;
    check({tag, ".pulse"}, done, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  int dones;

  initial begin
    clr = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.res", {hi, lo}, 64'h0);
    check("rst.dbz", dbz, 1'b0);
    check("rst.state", dbg_state, IDLE);
    @(negedge clk);
    clr = 1'b1;

    run_op("mulu_small", 2'b01, 32'h12, 32'h14, 32'h0, 32'h168, 1'b0, 35, 1'b0);
    run_op("mul_neg_pos", 2'b00, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 35, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("hold.res", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    run_op("mul_neg_neg", 2'b00, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h0, 32'h9, 1'b0, 35, 1'b0);
    run_op("mulu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, 35, 1'b0);
    run_op("mul_minmin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 35, 1'b0);
    run_op("mul_signed_f", 2'b00, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 35, 1'b0);

`ifdef MUL_DIV_UNIT_DIV_EN
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35, 1'b0);
    run_op("divu_small", 2'b11, 32'h14, 32'h12, 32'h2, 32'h1, 1'b0, 35, 1'b0);
    run_op("div_pos_neg", 2'b10, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, 35, 1'b0);
    run_op("divu_max", 2'b11, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0, 35, 1'b0);
    run_op("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 35, 1'b0);
    run_op("div_zero", 2'b10, 32'h18, 32'h0, 32'h18, 32'hFFFFFFFF, 1'b1, 2, 1'b0);
    run_op("divu_zero", 2'b11, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 2, 1'b0);
`else
    run_op("div_illegal", 2'b10, 32'h18, 32'h3, 32'h0, 32'h0, 1'b0, 2, 1'b0);
    run_op("divu_illegal", 2'b11, 32'h18, 32'h0, 32'h0, 32'h0, 1'b0, 2, 1'b0);
`endif

    // Start pulsed mid-operation with different operands.
    run_op("busy_start", 2'b01, 32'h3, 32'h4, 32'h0, 32'hC, 1'b0, 35, 1'b1);
    dones = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("busy_start.extra_done", dones, 0);

    // Reset asserted in the middle of RUN.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h1234; b = 32'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("clr.in_run", dbg_state, RUN);
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("clr.busy", busy, 1'b0);
    check("clr.res", {hi, lo}, 64'h0);
    check("clr.state", dbg_state, IDLE);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("clr.no_resume", dones, 0);
    run_op("after_clr", 2'b00, 32'h6, 32'h7, 32'h0, 32'h2A, 1'b0, 35, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are even numbers from 8 to 64.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clr  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation select: 00 MUL signed, 01 MULU, 10 DIV signed, 11 DIVU.
REQ-006 SHALL have port a  input  WIDTH  multiplicand or dividend.
REQ-007 SHALL have port b  input  WIDTH  multiplier or divisor.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking that hi/lo are valid.
REQ-010 SHALL have port hi  output  WIDTH  product upper half, or remainder.
REQ-011 SHALL have port lo  output  WIDTH  product lower half, or quotient.
REQ-012 SHALL have port dbz  output  1  divide-by-zero flag, valid with done.

Function
REQ-013 SHALL use FSM states IDLE, INIT, RUN, FIX and DONE; the transitions are IDLE->INIT on start, INIT->RUN, RUN->RUN for WIDTH iterations then RUN->FIX, FIX->DONE, and DONE->IDLE.
REQ-014 SHALL register a, b and op in the cycle start is accepted; later operand changes have no effect.
REQ-015 SHALL convert signed operands to magnitudes in INIT and record the result signs.
REQ-016 SHALL execute one radix-2 shift-add (MUL) or restoring shift-subtract (DIV) step per RUN cycle.
REQ-017 SHALL apply sign correction in FIX: product negated if the operand signs differ; quotient negated if they differ; remainder takes the sign of the dividend.
REQ-018 SHALL assert done in DONE; done goes high exactly WIDTH+3 rising edges after the edge that accepted start.
REQ-019 SHALL deliver the MUL result as the full 2*WIDTH product {hi,lo}.
REQ-020 SHALL produce lo = quotient truncated toward zero and hi = remainder for DIV.
REQ-021 SHALL, for signed most-negative / -1, give lo = most-negative value and hi = 0, with no flag.
REQ-022 SHALL, for DIV with b = 0, skip RUN (INIT->DONE) and give lo = all ones, hi = a, dbz = 1; done comes 2 cycles after acceptance.
REQ-023 SHALL ignore start while busy or in DONE.
REQ-024 SHALL hold hi, lo and dbz stable from done until the next accepted start.

Reset
REQ-025 SHALL, while clr = 0, force the state to IDLE and drive busy = 0, done = 0, hi = 0, lo = 0 and dbz = 0, including when an operation is in progress.
REQ-026 SHALL require a fresh start after reset is released; an aborted operation is never resumed.

Configuration
REQ-027 SHALL compile divide support only when MUL_DIV_UNIT_DIV_EN is defined.
REQ-028 SHALL, without MUL_DIV_UNIT_DIV_EN, treat op = 1x as illegal: done comes 2 cycles after acceptance with hi = lo = 0 and dbz = 0, and no divide hardware is synthesised.

Structure
REQ-029 SHALL place the op encoding, the FSM state enum and the iteration-counter width function in shared package mul_div_pkg.
REQ-030 SHALL implement operand magnitude and result negation in sub-module mul_div_sign_fix, which is reused for operands and results.

Verification (WIDTH = 32)
REQ-031 SHALL cover MULU with a = 0x12, b = 0x14 -> done at edge 35, hi = 0x00000000, lo = 0x00000168.
REQ-032 SHALL cover MUL with a = 0xFFFFFFFD, b = 0x5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
REQ-033 SHALL cover DIV with a = 0xFFFFFFF9, b = 0x2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; and DIVU with a = 0x14, b = 0x12 -> lo = 0x1, hi = 0x2.
REQ-034 SHALL cover DIV with b = 0, a = 0x18 -> done after 2 cycles, dbz = 1, lo = 0xFFFFFFFF, hi = 0x18.
REQ-035 SHALL cover start pulsed while busy with different operands -> the first result is unaffected and only one done pulse occurs.
REQ-036 SHALL cover clr driven low mid-RUN -> busy, hi and lo go to 0 immediately; a new MUL then completes normally.
